// File: rtl/div_unit_if.sv
// div_unit_if: operand/result bundle between the control FSM and the divider.
// Latency: none, wires only.
// Backpressure: none; the master must hold off new operations while busy is high.
//
// Signals: load/start strobes and a/b operands (master -> slave);
// hi/lo results, busy, done and div_zero status (slave -> master).
// DIV_UNSIGNED_EN adds the is_unsigned select, sampled together with start.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             load;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef DIV_UNSIGNED_EN
   logic             is_unsigned;
`endif
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;

`ifdef DIV_UNSIGNED_EN
   modport master (output load, start, a, b, is_unsigned,
                   input  hi, lo, busy, done, div_zero);
   modport slave  (input  load, start, a, b, is_unsigned,
                   output hi, lo, busy, done, div_zero);
`else
   modport master (output load, start, a, b,
                   input  hi, lo, busy, done, div_zero);
   modport slave  (input  load, start, a, b,
                   output hi, lo, busy, done, div_zero);
`endif
endinterface

// File: rtl/div_unit.sv
// div_unit: multicycle signed restoring divider (quotient -> lo, remainder -> hi).
// Latency: start sampled at edge N, results and done at edge N+WIDTH+1; div-by-zero flagged at edge N.
// Backpressure: load/start are ignored while busy; hi/lo hold until the next completed division.
//
// Ports: clk, reset (async, active-high), io_div (div_unit_if.slave):
//   load/start strobes, a/b operands in; hi/lo results, busy, done, div_zero out.
// Optional: DIV_UNSIGNED_EN adds io_div.is_unsigned for raw unsigned division.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   div_unit_if.slave  io_div
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvsr;
   logic [CW-1:0]    r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;

   logic             w_uns;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift_rem;
   logic [WIDTH:0]   w_trial;

`ifdef DIV_UNSIGNED_EN
   assign w_uns = io_div.is_unsigned;
`else
   assign w_uns = 1'b0;
`endif

   // Unsigned mode clears the sign flags and passes operands raw, so FIX
   // degenerates to a plain write of the results.
   assign w_a_neg = r_a[WIDTH-1] & ~w_uns;
   assign w_b_neg = r_b[WIDTH-1] & ~w_uns;
   assign w_a_mag = w_a_neg ? (~r_a + 1'b1) : r_a;
   assign w_b_mag = w_b_neg ? (~r_b + 1'b1) : r_b;

   // The remainder stays below the divisor, so the shifted value fits in
   // WIDTH+1 bits and the MSB of the WIDTH+1-bit difference is its sign.
   assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
   assign w_trial     = w_shift_rem - {1'b0, r_dvsr};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvsr     <= '0;
         r_cnt      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_div.load) begin
                  r_a        <= io_div.a;
                  r_b        <= io_div.b;
                  r_div_zero <= 1'b0;
               end else if (io_div.start) begin
                  if (r_b == '0) begin
                     r_div_zero <= 1'b1;
                     r_done     <= 1'b1;
                  end else begin
                     r_div_zero <= 1'b0;
                     r_quo      <= w_a_mag;
                     r_dvsr     <= w_b_mag;
                     r_neg_q    <= w_a_neg ^ w_b_neg;
                     r_neg_r    <= w_a_neg;
                     r_rem      <= '0;
                     r_cnt      <= CNT_INIT;
                     r_busy     <= 1'b1;
                     r_state    <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_trial[WIDTH] ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_lo    <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
               r_hi    <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io_div.hi       = r_hi;
   assign io_div.lo       = r_lo;
   assign io_div.busy     = r_busy;
   assign io_div.done     = r_done;
   assign io_div.div_zero = r_div_zero;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider for the multicycle MIPS datapath.
- Driven by the control FSM's `dloadab` (operand load) and `div` (start) strobes.
- Produces quotient to LO and remainder to HI through the `muxhigh`/`muxlow` path.
- Reports `div_zero` back to the control FSM, which raises the DIVZERO exception.
- Restoring algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- load  in  1  capture a/b into operand registers (from `dloadab`)
- start  in  1  begin division on the registered operands (from `div`)
- a  in  WIDTH  dividend (rs)
- b  in  WIDTH  divisor (rt)
- hi  out  WIDTH  remainder
- lo  out  WIDTH  quotient
- busy  out  1  high while the division is in progress
- done  out  1  one-cycle pulse when hi/lo are updated, or when a divide-by-zero is detected
- div_zero  out  1  divisor was zero at start

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - a_reg, b_reg, hi, lo, the working registers and the counter = 0.
  - busy = 0, done = 0, div_zero = 0.
  - Reset asserted mid-operation aborts the division with the same result; no partial result is written.
- States: IDLE, CALC, FIX.
- IDLE:
  - load=1: a_reg<=a, b_reg<=b, div_zero<=0. Load has priority; a start in the same cycle is ignored.
  - start=1, load=0, b_reg==0: div_zero<=1 and done pulses for 1 cycle. State stays IDLE; hi/lo are unchanged.
  - start=1, load=0, b_reg!=0: div_zero<=0. Capture |a_reg| and |b_reg| (two's-complement magnitude, treated as unsigned WIDTH bits) and the sign flags. Clear the partial remainder, set counter=WIDTH-1, busy<=1, go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem, dividend} left by 1.
  - trial = rem - divisor, evaluated WIDTH+1 bits wide.
  - trial non-negative: rem=trial and the shifted-in quotient bit = 1; otherwise restore rem and set the bit to 0.
  - Counter decrements each step. At counter==0 after the final step, go to FIX. Exactly WIDTH cycles are spent in CALC.
- FIX: apply signs, then write hi/lo, pulse done, clear busy, return to IDLE.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a) (truncation toward zero).
- Latency: with start sampled at edge N, hi/lo update and done=1 at edge N+WIDTH+1. done stays high for exactly one cycle. busy is high from edge N to edge N+WIDTH+1.
- load and start while busy are ignored; a_reg/b_reg are unchanged.
- hi/lo hold their last result until the next completed division; only reset clears them.
- Overflow case: -2^(WIDTH-1) / -1 gives lo=0x80000000, hi=0. It wraps silently; no exception and no div_zero.
- Zero dividend: lo=0, hi=0, full latency.
- div_zero is a level signal: it holds until the next load, or until a start with a nonzero divisor.

Optional Feature:
- Macro: DIV_UNSIGNED_EN.
- Defined:
  - Adds input port `is_unsigned` (1 bit), sampled together with start.
  - is_unsigned=1 skips the magnitude/sign handling: operands are used raw and FIX only writes the results.
  - Latency is the same as the signed path.
- Not defined:
  - The port is absent.
  - All divisions are signed.

Test Plan:
- load a=7, b=2; start 2 cycles later -> done exactly 33 cycles after start edge (WIDTH+1); lo=0x00000003, hi=0x00000001, div_zero=0.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; also a=7, b=-2 -> lo=0xFFFFFFFD, hi=0x00000001.
- a=100, b=0, start -> next cycle div_zero=1 and done=1 for one cycle, busy=0, hi/lo keep previous values; later load -> div_zero=0.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Start 50/3; assert reset at the 10th CALC cycle -> busy=0, hi=lo=0 immediately, no done pulse. Then load 9/3 and start -> lo=3, hi=0. A start pulse issued while busy has no effect.
- (DIV_UNSIGNED_EN) a=0xFFFFFFFF, b=2, is_unsigned=1 -> lo=0x7FFFFFFF, hi=1; same operands with is_unsigned=0 -> lo=0, hi=0xFFFFFFFF.
